// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, the NOP
// encoding, FSM state encodings and the IF/ID payload struct.
package if_fetch_pkg;

    localparam int unsigned INST_ADDR_W = 32;   // InstAddrBus width
    localparam int unsigned INST_W      = 32;   // InstBus width
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned INST_BYTES  = INST_W / BYTE_W;
    localparam int unsigned CNT_W       = 3;    // holds 0..INST_BYTES

    // addi x0, x0, 0
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

    // Payload presented at the IF/ID boundary
    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } if_id_t;

    // Address of byte idx of the instruction at base (32-bit modulo)
    function automatic logic [INST_ADDR_W-1:0] byte_addr(
        input logic [INST_ADDR_W-1:0] base,
        input logic [CNT_W-1:0]       idx
    );
        return base + INST_ADDR_W'(idx);
    endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache for the fetch stage.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears valid bits)
//   rd_addr       lookup PC (combinational read)
//   hit_c         lookup hit (combinational)
//   rd_data_c     cached word at the lookup index (combinational)
//   we            write strobe for a completed fetch
//   wr_addr       PC of the word being written
//   wr_data       assembled instruction word
module if_icache
    import if_fetch_pkg::*;
#(
    parameter int unsigned LINES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] rd_addr,
    output logic                   hit_c,
    output logic [INST_W-1:0]      rd_data_c,
    input  logic                   we,
    input  logic [INST_ADDR_W-1:0] wr_addr,
    input  logic [INST_W-1:0]      wr_data
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = INST_ADDR_W - IDX_W - 2;

    logic [INST_W-1:0] data_mem [LINES];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid_q;

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;
    logic [3:0]       unused_addr_bits;

    assign rd_idx = rd_addr[IDX_W+1:2];
    assign wr_idx = wr_addr[IDX_W+1:2];
    assign rd_tag = rd_addr[INST_ADDR_W-1:IDX_W+2];
    assign wr_tag = wr_addr[INST_ADDR_W-1:IDX_W+2];

    // Byte offset within a word does not select a line
    assign unused_addr_bits = {rd_addr[1:0], wr_addr[1:0]};

    // Per-line valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Data and tag storage; contents are qualified by valid_q only
    always_ff @(posedge clk) begin
        if (we) begin
            data_mem[wr_idx] <= wr_data;
            tag_mem[wr_idx]  <= wr_tag;
        end
    end

    assign hit_c     = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_data_c = data_mem[rd_idx];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Reads four little-endian bytes per instruction over
// a shared byte-wide memory port, presents pc/inst with a valid flag to IF/ID
// and applies branch/jump redirects from decode.
// Build option: define IF_ICACHE_EN to add a direct-mapped instruction cache
// (if_icache) that delivers hits one cycle after entering S_FETCH.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   stall          IF/ID does not accept this cycle
//   br, br_addr    redirect request and target (honoured only when !stall)
//   mem_req        byte read request
//   mem_addr       byte address
//   mem_gnt        request accepted this cycle
//   mem_rdata      data for the request granted in the previous cycle
//   pc_o, inst_o   fetched PC and instruction
//   inst_valid_o   pc_o/inst_o valid
module if_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INST     = if_fetch_pkg::NOP_INST,
    parameter int unsigned ICACHE_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br,
    input  logic [31:0] br_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    import if_fetch_pkg::*;

    fetch_state_t           state_q, state_d;
    logic [INST_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]       issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]       recv_cnt_q, recv_cnt_d;
    logic [INST_W-1:0]      asm_buf_q, asm_buf_d;
    logic                   pending_q, pending_d;
    if_id_t                 out_q, out_d;
    logic                   valid_q, valid_d;
    logic                   req_q, req_d;
    logic [INST_ADDR_W-1:0] addr_q, addr_d;
    logic                   hit_q, hit_d;
    logic [INST_W-1:0]      hit_data_q;

    logic                   redirect;
    logic                   grant;
    logic                   entering;
    logic                   cache_we;
    logic [INST_W-1:0]      asm_word;
    logic                   cache_hit_c;
    logic [INST_W-1:0]      cache_data_c;

    assign redirect = br & ~stall;
    assign grant    = req_q & mem_gnt;
    // Final byte merged straight from the bus so completion needs no extra cycle
    assign asm_word = {mem_rdata, asm_buf_q[INST_W-BYTE_W-1:0]};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            asm_buf_q   <= '0;
            pending_q   <= 1'b0;
            out_q.pc    <= '0;
            out_q.inst  <= NOP_INST;
            valid_q     <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            hit_q       <= 1'b0;
            hit_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            asm_buf_q   <= asm_buf_d;
            pending_q   <= pending_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            hit_q       <= hit_d;
            hit_data_q  <= cache_data_c;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        asm_buf_d   = asm_buf_q;
        pending_d   = 1'b0;
        out_d       = out_q;
        valid_d     = valid_q;
        cache_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (hit_q) begin
                    out_d.pc   = fetch_pc_q;
                    out_d.inst = hit_data_q;
                    valid_d    = 1'b1;
                    fetch_pc_d = fetch_pc_q + INST_ADDR_W'(INST_BYTES);
                    state_d    = S_HOLD;
                end else begin
                    if (grant) begin
                        issue_cnt_d = issue_cnt_q + CNT_W'(1);
                        pending_d   = 1'b1;
                    end
                    // Data of the previous cycle's grant
                    if (pending_q) begin
                        asm_buf_d[{recv_cnt_q[1:0], 3'b000} +: BYTE_W] = mem_rdata;
                        recv_cnt_d = recv_cnt_q + CNT_W'(1);
                        if (recv_cnt_q == CNT_W'(INST_BYTES - 1)) begin
                            out_d.pc   = fetch_pc_q;
                            out_d.inst = asm_word;
                            valid_d    = 1'b1;
                            fetch_pc_d = fetch_pc_q + INST_ADDR_W'(INST_BYTES);
                            cache_we   = 1'b1;
                            state_d    = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    valid_d     = 1'b0;
                    out_d.inst  = NOP_INST;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Redirect overrides everything, including a completing or held fetch
        if (redirect) begin
            fetch_pc_d  = br_addr;
            valid_d     = 1'b0;
            out_d.inst  = NOP_INST;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            pending_d   = 1'b0;
            cache_we    = 1'b0;
            state_d     = S_FETCH;
        end
    end

    // Cache is looked up with the next PC so a hit suppresses the first request
    assign entering = (state_d == S_FETCH) && ((state_q != S_FETCH) || redirect);
    assign hit_d    = entering && cache_hit_c;
    assign req_d    = (state_d == S_FETCH) && (issue_cnt_d < CNT_W'(INST_BYTES)) && !hit_d;
    assign addr_d   = req_d ? byte_addr(fetch_pc_d, issue_cnt_d) : addr_q;

`ifdef IF_ICACHE_EN
    if_icache #(
        .LINES(ICACHE_LINES)
    ) u_icache (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (fetch_pc_d),
        .hit_c    (cache_hit_c),
        .rd_data_c(cache_data_c),
        .we       (cache_we),
        .wr_addr  (fetch_pc_q),
        .wr_data  (asm_word)
    );
`else
    logic        unused_cache_we;
    logic [31:0] unused_cache_lines;

    assign cache_hit_c        = 1'b0;
    assign cache_data_c       = '0;
    assign unused_cache_we    = cache_we;
    assign unused_cache_lines = 32'(ICACHE_LINES);
`endif

    assign mem_req      = req_q;
    assign mem_addr     = addr_q;
    assign pc_o         = out_q.pc;
    assign inst_o       = out_q.inst;
    assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a byte-wide memory model and an expected
// pc/inst scoreboard.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] br_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [7:0]  mem_rdata;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    logic        gnt_en;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

`ifdef IF_ICACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t sb[$];

    if_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br          (br),
        .br_addr     (br_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rdata   (mem_rdata),
        .pc_o        (pc_o),
        .inst_o      (inst_o),
        .inst_valid_o(inst_valid_o)
    );

    always #5 clk = ~clk;

    assign mem_gnt = gnt_en;

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        case (a)
            32'h0:   return 8'h13;
            32'h1:   return 8'h05;
            32'h2:   return 8'h50;
            32'h3:   return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        return {mbyte(pc + 32'd3), mbyte(pc + 32'd2), mbyte(pc + 32'd1), mbyte(pc)};
    endfunction

    // Memory: answers the byte granted last cycle, junk otherwise
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req && mem_gnt) mem_rdata <= mbyte(mem_addr);
        else                    mem_rdata <= 8'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = exp_inst(pc);
        sb.push_back(e);
    endtask

    // Wait (bounded) for a delivered instruction and compare it to the scoreboard
    task automatic wait_valid(input string tag);
        exp_t e;
        int   n = 0;
        while (inst_valid_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(inst_valid_o), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_pc"}, pc_o, e.pc);
            chk({tag, "_inst"}, inst_o, e.inst);
        end else begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end
    endtask

    initial begin
        int start;
        rst = 1'b1; stall = 1'b0; br = 1'b0; br_addr = '0; gnt_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req",   32'(mem_req), 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_pc",    pc_o, 32'd0);
        chk("rst_inst",  inst_o, 32'h0000_0013);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        rst = 1'b0;

        // First fetch from RESET_PC, grant held high
        @(negedge clk);
        chk("f0_req",  32'(mem_req), 32'd1);
        chk("f0_addr", mem_addr, 32'h0);
        start = cyc;
        push(32'h0);
        wait_valid("f0");
        chk("f0_lat", 32'(cyc - start), 32'd5);
        chk("f0_lit", inst_o, 32'h0050_0513);

        // Next fetch at 0x4; grant withheld 3 cycles on byte 2
        @(negedge clk);
        chk("f1_req",   32'(mem_req), 32'd1);
        chk("f1_addr",  mem_addr, 32'h4);
        chk("f1_valid", 32'(inst_valid_o), 32'd0);
        start = cyc;
        push(32'h4);
        repeat (2) @(negedge clk);
        chk("g_addr6", mem_addr, 32'h6);
        gnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("g_hold_req",  32'(mem_req), 32'd1);
            chk("g_hold_addr", mem_addr, 32'h6);
        end
        gnt_en = 1'b1;
        wait_valid("f1");
        chk("f1_lat", 32'(cyc - start), 32'd8);

        // Stall 4 cycles in S_HOLD
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("st_valid", 32'(inst_valid_o), 32'd1);
            chk("st_pc",    pc_o, 32'h4);
            chk("st_inst",  inst_o, exp_inst(32'h4));
            chk("st_req",   32'(mem_req), 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("f2_req",   32'(mem_req), 32'd1);
        chk("f2_addr",  mem_addr, 32'h8);
        chk("f2_valid", 32'(inst_valid_o), 32'd0);

        // Redirect while byte 1 of 0x8 is granted
        @(negedge clk);
        chk("br_addr9", mem_addr, 32'h9);
        br = 1'b1; br_addr = 32'h100;
        @(negedge clk);
        br = 1'b0;
        chk("br_valid", 32'(inst_valid_o), 32'd0);
        chk("br_inst",  inst_o, 32'h0000_0013);
        chk("br_req",   32'(mem_req), 32'd1);
        chk("br_tgt",   mem_addr, 32'h100);
        start = cyc;
        push(32'h100);
        wait_valid("f100");
        chk("f100_lat", 32'(cyc - start), 32'd5);

        // Redirect blocked by stall, taken when stall drops
        stall = 1'b1; br = 1'b1; br_addr = 32'h200;
        @(negedge clk);
        chk("bs_valid", 32'(inst_valid_o), 32'd1);
        chk("bs_pc",    pc_o, 32'h100);
        chk("bs_req",   32'(mem_req), 32'd0);
        stall = 1'b0;
        @(negedge clk);
        br = 1'b0;
        chk("bs2_valid", 32'(inst_valid_o), 32'd0);
        chk("bs2_inst",  inst_o, 32'h0000_0013);
        chk("bs2_req",   32'(mem_req), 32'd1);
        chk("bs2_addr",  mem_addr, 32'h200);
        push(32'h200);
        wait_valid("f200");

        // PC wrap: 0xFFFF_FFFC + 4 -> 0
        @(negedge clk);
        chk("f204_addr", mem_addr, 32'h204);
        br = 1'b1; br_addr = 32'hFFFF_FFFC;
        @(negedge clk);
        br = 1'b0;
        chk("wr_addr", mem_addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC);
        wait_valid("fwrap");
        @(negedge clk);
        chk("wrap0_addr", mem_addr, 32'h0);
        push(32'h0);
        wait_valid("fwrap0");

        // Misaligned redirect target, raised as the 0x4 fetch starts
        @(negedge clk);
        chk("f4_req", 32'(mem_req), CACHE ? 32'd0 : 32'd1);
        br = 1'b1; br_addr = 32'h302;
        @(negedge clk);
        br = 1'b0;
        chk("ua_valid", 32'(inst_valid_o), 32'd0);
        chk("ua_inst",  inst_o, 32'h0000_0013);
        chk("ua_req",   32'(mem_req), 32'd1);
        chk("ua_addr",  mem_addr, 32'h302);
        start = cyc;
        push(32'h302);
        wait_valid("f302");
        chk("f302_lat", 32'(cyc - start), 32'd5);

        // Redirect in the cycle the 4th byte of 0x306 completes
        @(negedge clk);
        chk("f306_addr", mem_addr, 32'h306);
        repeat (4) @(negedge clk);
        chk("c5_req",   32'(mem_req), 32'd0);
        chk("c5_valid", 32'(inst_valid_o), 32'd0);
        br = 1'b1; br_addr = 32'h40;
        @(negedge clk);
        br = 1'b0;
        chk("c5b_valid", 32'(inst_valid_o), 32'd0);
        chk("c5b_req",   32'(mem_req), 32'd1);
        chk("c5b_addr",  mem_addr, 32'h40);
        push(32'h40);
        wait_valid("f40");

        // Two-instruction loop at 0x10/0x14, run twice
        @(negedge clk);
        br = 1'b1; br_addr = 32'h10;
        @(negedge clk);
        br = 1'b0;
        chk("l1_addr", mem_addr, 32'h10);
        push(32'h10);
        wait_valid("l1a");
        @(negedge clk);
        chk("l1b_addr", mem_addr, 32'h14);
        push(32'h14);
        wait_valid("l1b");
        @(negedge clk);
        br = 1'b1; br_addr = 32'h10;
        @(negedge clk);
        br = 1'b0;
        chk("l2a_req", 32'(mem_req), CACHE ? 32'd0 : 32'd1);
        start = cyc;
        push(32'h10);
        wait_valid("l2a");
        chk("l2a_lat", 32'(cyc - start), CACHE ? 32'd1 : 32'd5);
        @(negedge clk);
        chk("l2b_req", 32'(mem_req), CACHE ? 32'd0 : 32'd1);
        start = cyc;
        push(32'h14);
        wait_valid("l2b");
        chk("l2b_lat", 32'(cyc - start), CACHE ? 32'd1 : 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage: the producer end of the decode stage's pc/inst input and the consumer end of its br/br_addr redirect.
- Fetches 32-bit instructions over a shared byte-wide memory port, assembling four little-endian bytes per instruction.
- Presents pc/inst with a valid flag to the IF/ID boundary.
- Applies branch/jump redirects, discarding wrong-path bytes and instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- NOP_INST, 32'h0000_0013, value driven on inst_o when no valid instruction (addi x0,x0,0).
- ICACHE_LINES, 16, entries in the optional cache (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  downstream stall; IF/ID does not accept this cycle.
- br  in  1  redirect request from decode.
- br_addr  in  32  redirect target.
- mem_req  out  1  byte-read request.
- mem_addr  out  32  byte address.
- mem_gnt  in  1  request accepted this cycle.
- mem_rdata  in  8  data for the request granted in the previous cycle.
- pc_o  out  32  PC of inst_o.
- inst_o  out  32  fetched instruction.
- inst_valid_o  out  1  inst_o/pc_o valid.

Behaviour:
- Reset values:
  - mem_req=0, mem_addr=0, pc_o=0, inst_o=NOP_INST, inst_valid_o=0.
  - State=S_IDLE; fetch_pc=RESET_PC; issue_cnt=recv_cnt=0.
  - Reset dominates all other inputs. Reset asserted mid-fetch abandons the fetch; an rdata byte arriving the cycle after reset is ignored.
- States:
  - S_IDLE: for one cycle after reset only, then S_FETCH.
  - S_FETCH:
    - Drive mem_req=1, mem_addr=fetch_pc+issue_cnt while issue_cnt<4.
    - On mem_gnt, issue_cnt++.
    - mem_rdata is captured the cycle after each grant into buf[8*recv_cnt+:8], then recv_cnt++.
    - Back-to-back grants are allowed: the next byte is issued in the same cycle the previous byte is captured.
    - After the 4th byte is captured: inst_o<=buf, pc_o<=fetch_pc, inst_valid_o<=1, fetch_pc<=fetch_pc+4, go to S_HOLD.
    - Minimum latency is 5 cycles per instruction with mem_gnt held high.
  - S_HOLD:
    - mem_req=0.
    - If !stall: the instruction is consumed that edge; inst_valid_o<=0, issue_cnt=recv_cnt=0, go to S_FETCH (next fetch issues in the following cycle).
    - If stall: hold pc_o/inst_o/inst_valid_o unchanged.
- mem_gnt=0 while requesting: hold mem_addr and retry; no counter change.
- stall during S_FETCH: fetching continues; the result parks in S_HOLD.
- Redirect:
  - br is honoured only in cycles with stall=0.
  - Effect at that edge: fetch_pc<=br_addr, inst_valid_o<=0, inst_o<=NOP_INST, counters cleared, state S_FETCH.
  - Any byte granted that cycle or earlier whose data is still in flight is dropped; its rdata next cycle is not captured.
  - A held S_HOLD instruction is discarded (wrong path).
  - br and a completing 4th byte in the same cycle: the redirect wins and the assembled instruction is discarded.
- br_addr[1:0]≠0: accepted as-is (no check); bytes are fetched from the exact address.
- PC arithmetic is 32-bit modulo; 0xFFFF_FFFC+4 wraps to 0.

Optional Feature:
- IF_ICACHE_EN defined:
  - Adds a direct-mapped cache of ICACHE_LINES words, indexed by pc[log2(L)+1:2], with tag=pc[31:log2(L)+2] and per-line valid.
  - On entering S_FETCH, a hit loads inst_o/pc_o with inst_valid_o=1 on the next edge (1-cycle latency) with no mem_req.
  - A miss fetches as above and writes the line on completion.
  - Reset clears all valid bits.
  - Redirect during a hit cycle: the redirect wins.
- Undefined: no cache storage; every fetch uses the memory port.

Decomposition:
- Shared defines file:
  - State encodings S_IDLE/S_FETCH/S_HOLD.
  - NOP_INST constant.
  - Existing InstAddrBus/InstBus widths.
- Sub-module if_icache: storage, tag compare, hit flag, write port. It is instantiated only under IF_ICACHE_EN.

Test Plan:
- Reset release, mem_gnt=1, memory at 0x0 = 13 05 50 00 → after 5 cycles pc_o=0, inst_o=0x00500513, inst_valid_o=1; next fetch issues addr 0x4.
- mem_gnt low 3 cycles on byte 2 → mem_addr held at fetch_pc+2 throughout; assembled instruction still correct, delivered 3 cycles later.
- stall=1 for 4 cycles while in S_HOLD → pc_o/inst_o/inst_valid_o stable for all 4 cycles; mem_req=0.
- br=1, br_addr=0x100 while byte 1 of 0x8 is in flight → that byte is ignored; inst_valid_o=0; next mem_addr=0x100; delivered pc_o=0x100.
- br=1 together with stall=1 → no redirect; with stall dropping next cycle and br still high → redirect occurs then.
- IF_ICACHE_EN: loop of 2 instructions at 0x10/0x14 → second iteration is delivered 1 cycle after S_FETCH with no mem_req.
